// File: rtl/recirc_pkg.sv
// recirc_pkg: FSM state encoding and default lane count for the recirculation scheduler.
package recirc_pkg;
    localparam int LANES_DEF = 4;
    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;
endpackage

// File: rtl/recirc_lane_counter.sv
// recirc_lane_counter: per-lane saturating count of consecutive recirculations.
module recirc_lane_counter #(
    parameter int MAX = 8
) (
    input  logic       clk_f,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    output logic [7:0] cnt,
    output logic       sat
);
    assign sat = cnt == 8'(MAX);
    always_ff @(posedge clk_f or negedge reset)
        if (!reset) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc && !sat) cnt <= cnt + 8'd1;
endmodule

// File: rtl/recirc_scheduler.sv
// recirc_scheduler: per-lane forward/recirculate decisions and stage sequencing.
// Define RECIRC_WATCHDOG_EN to build the per-lane stuck-lane watchdog and ERROR state.
module recirc_scheduler
    import recirc_pkg::*;
#(
    parameter int LANES       = LANES_DEF,
    parameter int MAX_RECIRC  = 8,
    parameter int INIT_CYCLES = 4
) (
    input  logic             clk_f,
    input  logic             reset,
    input  logic             init,
    input  logic [LANES-1:0] valid_in,
    input  logic [LANES-1:0] fifo_afull,
    input  logic [LANES-1:0] fifo_empty,
    output logic [LANES-1:0] fwd_en,
    output logic [LANES-1:0] recirc_en,
    output logic             IDLE_OUT,
    output logic [2:0]       state,
    output logic [LANES-1:0] error_lane
);
    state_t st, nxt;
    logic [3:0] init_cnt;
    logic run, hold;
    logic [LANES-1:0] hit;
    assign run   = st == ST_IDLE || st == ST_ACTIVE;
    assign hold  = st == ST_RESET || st == ST_INIT;
    assign state = st;
`ifdef RECIRC_WATCHDOG_EN
    logic [LANES-1:0] inc, clr, sat;
    logic [7:0] cnt [LANES];
    assign inc = {LANES{run}} & valid_in & fifo_afull;
    assign clr = ~valid_in | ({LANES{run}} & ~fifo_afull);
    for (genvar i = 0; i < LANES; i++) begin : g_cnt
        recirc_lane_counter #(.MAX(MAX_RECIRC)) u_cnt (
            .clk_f(clk_f),
            .reset(reset),
            .inc(inc[i]),
            .clr(clr[i]),
            .cnt(cnt[i]),
            .sat(sat[i])
        );
        // a saturated lane that keeps recirculating still counts as reaching the limit
        assign hit[i] = inc[i] && (sat[i] || cnt[i] == 8'(MAX_RECIRC - 1));
    end
    always_ff @(posedge clk_f or negedge reset)
        if (!reset) error_lane <= '0;
        else error_lane <= (nxt == ST_INIT) ? '0 : error_lane | hit;
`else
    assign hit        = '0;
    assign error_lane = '0;
`endif
    always_comb begin
        nxt = st;
        if (init) nxt = ST_INIT;
        else
            case (st)
                ST_RESET:  nxt = ST_INIT;
                ST_INIT:   nxt = init_cnt >= 4'(INIT_CYCLES - 1) ? ST_IDLE : ST_INIT;
                ST_IDLE:   nxt = |valid_in ? ST_ACTIVE : ST_IDLE;
                ST_ACTIVE: nxt = |hit ? ST_ERROR : (!(|valid_in) && &fifo_empty) ? ST_IDLE : ST_ACTIVE;
                default:   nxt = st;
            endcase
    end
    always_ff @(posedge clk_f or negedge reset)
        if (!reset) begin
            st        <= ST_RESET;
            init_cnt  <= '0;
            fwd_en    <= '0;
            recirc_en <= '0;
            IDLE_OUT  <= 1'b0;
        end else begin
            st        <= nxt;
            init_cnt  <= (st == ST_INIT && nxt == ST_INIT && !init) ? init_cnt + 4'd1 : 4'd0;
            fwd_en    <= {LANES{run}} & valid_in & ~fifo_afull;
            recirc_en <= (({LANES{run}} & fifo_afull) | {LANES{hold}}) & valid_in;
            IDLE_OUT  <= nxt == ST_IDLE;
        end
endmodule

// File: tb/tb_recirc_scheduler.sv
// tb_recirc_scheduler: directed and randomized checks of recirc_scheduler against a behavioural model.
module tb_recirc_scheduler;
    localparam int MAXR  = 8;
    localparam int INITC = 4;
`ifdef RECIRC_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif
    logic clk_f = 1'b0, reset = 1'b0, init = 1'b0;
    logic [3:0] valid_in = 4'hF, fifo_afull = 4'h0, fifo_empty = 4'hF;
    logic [3:0] fwd_en, recirc_en, error_lane;
    logic IDLE_OUT;
    logic [2:0] state;
    int checks = 0, errors = 0;
    int ms, icnt;
    int mc [4];
    logic [3:0] mf, mr, me;
    logic mi;
    always #5 clk_f = ~clk_f;
    recirc_scheduler #(.LANES(4), .MAX_RECIRC(MAXR), .INIT_CYCLES(INITC)) dut (
        .clk_f(clk_f),
        .reset(reset),
        .init(init),
        .valid_in(valid_in),
        .fifo_afull(fifo_afull),
        .fifo_empty(fifo_empty),
        .fwd_en(fwd_en),
        .recirc_en(recirc_en),
        .IDLE_OUT(IDLE_OUT),
        .state(state),
        .error_lane(error_lane)
    );
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic model_reset();
        ms = 0; icnt = 0; mf = 0; mr = 0; me = 0; mi = 0;
        for (int l = 0; l < 4; l++) mc[l] = 0;
    endtask
    task automatic check_model(input string ctx);
        check({ctx, "_state"}, 8'(state), 8'(ms));
        check({ctx, "_fwd"}, 8'(fwd_en), 8'(mf));
        check({ctx, "_recirc"}, 8'(recirc_en), 8'(mr));
        check({ctx, "_idle"}, 8'(IDLE_OUT), 8'(mi));
        check({ctx, "_err"}, 8'(error_lane), 8'(me));
    endtask
    // apply one cycle of inputs, advance the model by the stage rules, compare after the edge
    task automatic step(input logic [3:0] v, input logic [3:0] a, input logic [3:0] e, input logic i);
        int ns;
        bit run, hold;
        logic [3:0] hit, f, r;
        valid_in = v; fifo_afull = a; fifo_empty = e; init = i;
        run = ms == 2 || ms == 3;
        hold = ms < 2;
        hit = 0; f = 0; r = 0;
        for (int l = 0; l < 4; l++) begin
            f[l] = run && v[l] && !a[l];
            r[l] = v[l] && (hold || (run && a[l]));
            if (WD && run && v[l] && a[l] && mc[l] + 1 >= MAXR) hit[l] = 1'b1;
            if (!v[l]) mc[l] = 0;
            else if (run) mc[l] = a[l] ? ((mc[l] + 1 > MAXR) ? MAXR : mc[l] + 1) : 0;
        end
        if (i) ns = 1;
        else if (ms == 0) ns = 1;
        else if (ms == 1) ns = (icnt + 1 >= INITC) ? 2 : 1;
        else if (ms == 2) ns = (v != 0) ? 3 : 2;
        else if (ms == 3) ns = (hit != 0) ? 4 : (v == 0 && e == 4'hF) ? 2 : 3;
        else ns = 4;
        icnt = (ms == 1 && ns == 1 && !i) ? icnt + 1 : 0;
        me = (ns == 1) ? 4'h0 : (me | hit);
        ms = ns; mf = f; mr = r; mi = (ns == 2);
        @(posedge clk_f);
        #1;
        check_model("step");
    endtask
    task automatic async_rst();
        #2 reset = 1'b0;
        #1;
        check("arst_fwd", 8'(fwd_en), 8'h0);
        check("arst_recirc", 8'(recirc_en), 8'h0);
        check("arst_idle", 8'(IDLE_OUT), 8'h0);
        check("arst_state", 8'(state), 8'h0);
        check("arst_err", 8'(error_lane), 8'h0);
        model_reset();
        @(negedge clk_f);
        reset = 1'b1;
    endtask
    initial begin
        model_reset();
        repeat (2) @(posedge clk_f);
        #1;
        check_model("rst_hold");
        reset = 1'b1;
        step(4'h0, 4'h0, 4'hF, 1'b0);
        check("rel_state1", 8'(state), 8'h1);
        repeat (4) step(4'h0, 4'h0, 4'hF, 1'b0);
        check("init_done_state", 8'(state), 8'h2);
        check("init_done_idle", 8'(IDLE_OUT), 8'h1);
        step(4'b0101, 4'h0, 4'h0, 1'b0);
        check("first_fwd", 8'(fwd_en), 8'h5);
        check("first_state", 8'(state), 8'h3);
        step(4'hF, 4'b0010, 4'h0, 1'b0);
        check("mix_fwd", 8'(fwd_en), 8'hD);
        check("mix_recirc", 8'(recirc_en), 8'h2);
        repeat (MAXR) step(4'b0100, 4'b0100, 4'h0, 1'b0);
        check("wd_state", 8'(state), WD ? 8'h4 : 8'h3);
        check("wd_err", 8'(error_lane), WD ? 8'h4 : 8'h0);
        step(4'b0100, 4'b0100, 4'h0, 1'b0);
        check("wd_drop", 8'(recirc_en), WD ? 8'h0 : 8'h4);
        step(4'h0, 4'h0, 4'h0, 1'b1);
        check("init_state", 8'(state), 8'h1);
        check("init_err", 8'(error_lane), 8'h0);
        repeat (INITC) step(4'h0, 4'h0, 4'hF, 1'b0);
        step(4'b0001, 4'h0, 4'h0, 1'b0);
        step(4'h0, 4'h0, 4'b1110, 1'b0);
        check("drain_state", 8'(state), 8'h3);
        step(4'h0, 4'h0, 4'hF, 1'b0);
        check("empty_state", 8'(state), 8'h2);
        check("empty_idle", 8'(IDLE_OUT), 8'h1);
        step(4'hF, 4'h0, 4'h0, 1'b0);
        async_rst();
        for (int n = 0; n < 600; n++) begin
            logic [3:0] v, a, e;
            bit sticky;
            sticky = ((n / 40) % 2) == 1;
            v = sticky ? (4'($urandom) | 4'($urandom)) : 4'($urandom);
            a = sticky ? ~(4'($urandom) & 4'($urandom) & 4'($urandom)) : 4'($urandom);
            e = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
            if (!sticky && $urandom_range(0, 2) == 0) v = 4'h0;
            if ($urandom_range(0, 99) == 0) async_rst();
            else step(v, a, e, $urandom_range(0, 59) == 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
